// File: rtl/blockram_dp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : blockram_dp_if                                               |
// | Description : Bundle of the fetch (A) and load/store (B) request/response  |
// |               signals of blockram_dp. The master drives requests, the      |
// |               slave (the RAM) drives responses.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface blockram_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Port A: read-only instruction fetch
    logic                  a_req;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_rdata;
    logic                  a_valid;
    logic                  a_err;

    // Port B: read/write data access with byte enables
    logic                  b_req;
    logic                  b_we;
    logic [DATA_W/8-1:0]   b_be;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W-1:0]     b_wdata;
    logic [DATA_W-1:0]     b_rdata;
    logic                  b_valid;
    logic                  b_err;

    modport master (
        output a_req, a_addr,
        input  a_rdata, a_valid, a_err,
        output b_req, b_we, b_be, b_addr, b_wdata,
        input  b_rdata, b_valid, b_err
    );

    modport slave (
        input  a_req, a_addr,
        output a_rdata, a_valid, a_err,
        input  b_req, b_we, b_be, b_addr, b_wdata,
        output b_rdata, b_valid, b_err
    );
endinterface
`default_nettype wire

// File: rtl/blockram_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : blockram_dp                                                  |
// | Description : Dual-port byte-addressed block RAM. Port A is a read-only    |
// |               fetch port, port B a read-first read/write data port with    |
// |               byte enables. Both ports are fully pipelined with a fixed    |
// |               read latency of RD_LAT (1 or 2) and flag misaligned or       |
// |               out-of-range accesses.                                       |
// | Options     : `define BRAM_BYPASS_EN to forward port-B write bytes to a    |
// |               same-cycle port-A read of the same word.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module blockram_dp #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1,
    parameter     INIT_FILE = ""
) (
    input wire logic     clk,
    input wire logic     rst,
    blockram_dp_if.slave bus
);

    localparam int                c_LANES    = DATA_W / 8;
    localparam int                c_OFF_W    = $clog2(c_LANES);
    localparam int                c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] c_OFF_MASK = ADDR_W'(c_LANES - 1);
    localparam logic [ADDR_W-1:0] c_DEPTH_A  = ADDR_W'(DEPTH);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("blockram_dp: RD_LAT must be 1 or 2");
        end
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
            $error("blockram_dp: DATA_W must be a non-zero multiple of 8");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Storage (contents are never reset)
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Address decode. The full word index is compared against DEPTH so an
    // out-of-range address is flagged rather than aliased onto a real word.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_a_word;
    logic [ADDR_W-1:0]  w_b_word;
    logic [c_IDX_W-1:0] w_a_idx;
    logic [c_IDX_W-1:0] w_b_idx;
    logic               w_a_err;
    logic               w_b_err;
    logic               w_b_wr;

    assign w_a_word = bus.a_addr >> c_OFF_W;
    assign w_b_word = bus.b_addr >> c_OFF_W;
    assign w_a_idx  = w_a_word[c_IDX_W-1:0];
    assign w_b_idx  = w_b_word[c_IDX_W-1:0];
    assign w_a_err  = (|(bus.a_addr & c_OFF_MASK)) | (w_a_word >= c_DEPTH_A);
    assign w_b_err  = (|(bus.b_addr & c_OFF_MASK)) | (w_b_word >= c_DEPTH_A);

    // A write only happens for a legal, enabled port-B write request
    assign w_b_wr   = bus.b_req & bus.b_we & ~w_b_err;

    // ------------------------------------------------------------------------
    // Array read ports (old contents: writes land at the same edge)
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_a_mem;
    logic [DATA_W-1:0] w_b_mem;
    logic [DATA_W-1:0] w_a_fetch;

    assign w_a_mem = r_mem[w_a_idx];
    assign w_b_mem = r_mem[w_b_idx];

`ifdef BRAM_BYPASS_EN
    logic w_hit;

    assign w_hit = bus.a_req & ~w_a_err & w_b_wr & (w_a_idx == w_b_idx);

    // Merge the enabled port-B write bytes into a colliding port-A read
    always_comb begin
        w_a_fetch = w_a_mem;
        if (w_hit) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (bus.b_be[i]) begin
                    w_a_fetch[i*8 +: 8] = bus.b_wdata[i*8 +: 8];
                end
            end
        end
    end
`else
    // Without bypass a colliding port-A read simply sees the old word
    assign w_a_fetch = w_a_mem;
`endif

    // Byte-lane write of port B; disabled lanes keep their contents
    always_ff @(posedge clk) begin
        if (w_b_wr) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (bus.b_be[i]) begin
                    r_mem[w_b_idx][i*8 +: 8] <= bus.b_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // First pipeline stage. Data registers only load on a request so the
    // last response stays visible between pulses; err is qualified by req so
    // it only ever shows together with valid.
    // ------------------------------------------------------------------------
    logic              r_a_v1;
    logic              r_a_e1;
    logic [DATA_W-1:0] r_a_d1;
    logic              r_b_v1;
    logic              r_b_e1;
    logic [DATA_W-1:0] r_b_d1;

    // Port A stage 1: capture fetch response, zero data on error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_v1 <= 1'b0;
            r_a_e1 <= 1'b0;
            r_a_d1 <= '0;
        end else begin
            r_a_v1 <= bus.a_req;
            r_a_e1 <= bus.a_req & w_a_err;
            if (bus.a_req) begin
                r_a_d1 <= w_a_err ? '0 : w_a_fetch;
            end
        end
    end

    // Port B stage 1: capture pre-write word (read-first), zero data on error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_v1 <= 1'b0;
            r_b_e1 <= 1'b0;
            r_b_d1 <= '0;
        end else begin
            r_b_v1 <= bus.b_req;
            r_b_e1 <= bus.b_req & w_b_err;
            if (bus.b_req) begin
                r_b_d1 <= w_b_err ? '0 : w_b_mem;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_a_v2;
            logic              r_a_e2;
            logic [DATA_W-1:0] r_a_d2;
            logic              r_b_v2;
            logic              r_b_e2;
            logic [DATA_W-1:0] r_b_d2;

            // Port A stage 2: forward stage-1 response, hold data when idle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_v2 <= 1'b0;
                    r_a_e2 <= 1'b0;
                    r_a_d2 <= '0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_a_e2 <= r_a_e1;
                    if (r_a_v1) begin
                        r_a_d2 <= r_a_d1;
                    end
                end
            end

            // Port B stage 2: forward stage-1 response, hold data when idle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_b_v2 <= 1'b0;
                    r_b_e2 <= 1'b0;
                    r_b_d2 <= '0;
                end else begin
                    r_b_v2 <= r_b_v1;
                    r_b_e2 <= r_b_e1;
                    if (r_b_v1) begin
                        r_b_d2 <= r_b_d1;
                    end
                end
            end

            assign bus.a_valid = r_a_v2;
            assign bus.a_err   = r_a_e2;
            assign bus.a_rdata = r_a_d2;
            assign bus.b_valid = r_b_v2;
            assign bus.b_err   = r_b_e2;
            assign bus.b_rdata = r_b_d2;
        end else begin : g_lat1
            assign bus.a_valid = r_a_v1;
            assign bus.a_err   = r_a_e1;
            assign bus.a_rdata = r_a_d1;
            assign bus.b_valid = r_b_v1;
            assign bus.b_err   = r_b_e1;
            assign bus.b_rdata = r_b_d1;
        end
    endgenerate

endmodule
`default_nettype wire
